// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive framer.
// State encodings and default framing constants.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CSUM,
        DRAIN
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF      = 8'hA5;
    localparam int         MAX_LEN_DEF        = 16;
    localparam int         TIMEOUT_CYCLES_DEF = 8680;
    localparam int         CYCLES_PER_BIT     = 434;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: single write port,
// combinational read port, contents never reset.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    // capture payload bytes as they arrive
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_framer.sv
// Frames the UART byte stream: SYNC, LEN, payload, checksum.
// Verified payloads are streamed out over valid/ready.
import uart_pkg::*;

module uart_rx_framer #(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         MAX_LEN        = MAX_LEN_DEF,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic [7:0] rx_msg,
    input  logic       rx_complete,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [4:0] frame_len,
    output logic       csum_err,
    output logic       len_err,
    output logic       timeout_err,
    output logic       overrun
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int IW = $clog2(TIMEOUT_CYCLES);
    // idle count on the cycle before expiry; the next idle cycle fires
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 2);

    state_t        r_state, w_state;
    logic [4:0]    r_len,   w_len;
    logic [7:0]    r_sum,   w_sum;
    logic [AW-1:0] r_wptr,  w_wptr;
    logic [AW-1:0] r_rptr,  w_rptr;
    logic [IW-1:0] r_idle,  w_idle;
    logic          r_csum_err, w_csum_err;
    logic          r_len_err,  w_len_err;
    logic          r_to_err,   w_to_err;
    logic          r_ovr,      w_ovr;
    logic          w_we;
    logic          w_fire;
    logic          w_in_frame;
    logic [7:0]    w_rdata;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk_50M),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (rx_msg),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign out_valid   = (r_state == DRAIN);
    assign out_data    = out_valid ? w_rdata : 8'h00;
    assign out_last    = out_valid &&
                         (int'(r_rptr) == int'(r_len) - 1);
    assign frame_len   = r_len;
    assign csum_err    = r_csum_err;
    assign len_err     = r_len_err;
    assign timeout_err = r_to_err;
    assign overrun     = r_ovr;

    assign w_fire     = out_valid && out_ready;
    assign w_in_frame = (r_state == LEN) ||
                        (r_state == PAYLOAD) ||
                        (r_state == CSUM);

    // next-state, datapath updates and error pulses
    always_comb begin
        w_state    = r_state;
        w_len      = r_len;
        w_sum      = r_sum;
        w_wptr     = r_wptr;
        w_rptr     = r_rptr;
        w_idle     = '0;
        w_csum_err = 1'b0;
        w_len_err  = 1'b0;
        w_to_err   = 1'b0;
        w_ovr      = 1'b0;
        w_we       = 1'b0;
        unique case (r_state)
            HUNT: begin
                if (rx_complete && rx_msg == SYNC_BYTE) begin
                    w_state = LEN;
                end
            end
            LEN: begin
                if (rx_complete) begin
                    if (rx_msg == 8'h00 ||
                        int'(rx_msg) > MAX_LEN) begin
                        w_len_err = 1'b1;
                        w_state   = HUNT;
                    end else begin
                        w_len   = rx_msg[4:0];
                        w_sum   = rx_msg;
                        w_wptr  = '0;
                        w_state = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_complete) begin
                    w_we   = 1'b1;
                    w_sum  = r_sum + rx_msg;
                    w_wptr = r_wptr + 1'b1;
                    if (int'(r_wptr) == int'(r_len) - 1) begin
                        w_state = CSUM;
                    end
                end
            end
            CSUM: begin
                if (rx_complete) begin
                    if (rx_msg == r_sum) begin
                        w_rptr  = '0;
                        w_state = DRAIN;
                    end else begin
                        w_csum_err = 1'b1;
                        w_state    = HUNT;
                    end
                end
            end
            DRAIN: begin
                w_ovr = rx_complete;
                if (w_fire) begin
                    if (out_last) begin
                        w_rptr  = '0;
                        w_state = HUNT;
                    end else begin
                        w_rptr = r_rptr + 1'b1;
                    end
                end
            end
            default: begin
                w_state = HUNT;
            end
        endcase
        // a byte on the expiry cycle clears the count instead
        if (w_in_frame && !rx_complete) begin
            if (r_idle == IDLE_LAST) begin
                w_to_err = 1'b1;
                w_state  = HUNT;
            end else begin
                w_idle = r_idle + 1'b1;
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_state    <= HUNT;
            r_len      <= '0;
            r_sum      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_idle     <= '0;
            r_csum_err <= 1'b0;
            r_len_err  <= 1'b0;
            r_to_err   <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_len      <= w_len;
            r_sum      <= w_sum;
            r_wptr     <= w_wptr;
            r_rptr     <= w_rptr;
            r_idle     <= w_idle;
            r_csum_err <= w_csum_err;
            r_len_err  <= w_len_err;
            r_to_err   <= w_to_err;
            r_ovr      <= w_ovr;
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: frame-level
// queue model compared every cycle, plus literal pins.
module tb_uart_rx_framer;

    localparam int T = 8680;

    typedef logic [7:0] bq_t[$];

    logic       clk_50M = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_msg = 8'h00;
    logic       rx_complete = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic [4:0] frame_len;
    logic       csum_err;
    logic       len_err;
    logic       timeout_err;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    uart_rx_framer dut (
        .clk_50M     (clk_50M),
        .rst         (rst),
        .rx_msg      (rx_msg),
        .rx_complete (rx_complete),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .frame_len   (frame_len),
        .csum_err    (csum_err),
        .len_err     (len_err),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    always #10 clk_50M = ~clk_50M;

    // frame-level model: bytes of the frame in progress,
    // and the verified payload still waiting to be read
    bq_t m_frm;
    bq_t m_out;
    int  m_idle = 0;
    int  m_flen = 0;
    bit  e_csum = 0, e_len = 0, e_to = 0, e_ovr = 0;

    // observation records
    bq_t got;
    int  got_cyc[$];
    int  last_idx = -1;
    int  last_flen = -1;
    int  n_csum = 0, n_len = 0, n_to = 0, n_ovr = 0;
    int  cyc = 0;
    bit  prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_frm.delete();
        m_out.delete();
        m_idle = 0;
        {e_csum, e_len, e_to, e_ovr} = 4'b0;
    endtask

    task automatic model_step(input bit v,
                              input logic [7:0] b,
                              input bit r);
        int s;
        int n;
        {e_csum, e_len, e_to, e_ovr} = 4'b0;
        if (m_out.size() > 0) begin
            if (v) e_ovr = 1;
            if (r) void'(m_out.pop_front());
        end else if (m_frm.size() == 0) begin
            if (v && b == 8'hA5) begin
                m_frm.push_back(b);
                m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            m_frm.push_back(b);
            n = m_frm.size();
            if (n == 2 && (b == 0 || int'(b) > 16)) begin
                e_len = 1;
                m_frm.delete();
            end else if (n >= 3 && n == int'(m_frm[1]) + 3) begin
                s = 0;
                for (int i = 1; i < n - 1; i++) s += int'(m_frm[i]);
                if ((s % 256) == int'(b)) begin
                    for (int i = 2; i < n - 1; i++)
                        m_out.push_back(m_frm[i]);
                    m_flen = int'(m_frm[1]);
                end else begin
                    e_csum = 1;
                end
                m_frm.delete();
            end
        end else begin
            m_idle++;
            if (m_idle == T - 1) begin
                e_to = 1;
                m_idle = 0;
                m_frm.delete();
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] b,
                        input bit r);
        rx_complete = v;
        rx_msg = b;
        out_ready = r;
        @(posedge clk_50M);
        if (!rst) model_step(v, b, r);
        #1;
    endtask

    task automatic send(input bq_t q, input bit r);
        foreach (q[i]) step(1'b1, q[i], r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic clear_obs();
        got.delete();
        got_cyc.delete();
        last_idx = -1;
        last_flen = -1;
        n_csum = 0; n_len = 0; n_to = 0; n_ovr = 0;
    endtask

    task automatic check_got(input string nm, input bq_t e);
        check({nm, "_count"}, got.size(), e.size());
        foreach (e[i]) begin
            if (i < got.size())
                check($sformatf("%s_byte%0d", nm, i), got[i], e[i]);
        end
    endtask

    // per-cycle comparison against the model plus observation logging
    always @(negedge clk_50M) begin
        cyc++;
        check("valid", out_valid, m_out.size() > 0);
        check("last", out_last, m_out.size() == 1);
        if (m_out.size() > 0) begin
            check("data", out_data, m_out[0]);
            check("frame_len", frame_len, m_flen);
        end
        check("csum_err", csum_err, e_csum);
        check("len_err", len_err, e_len);
        check("timeout_err", timeout_err, e_to);
        check("overrun", overrun, e_ovr);
        if (prev_stall) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, prev_data);
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
        if (csum_err) n_csum++;
        if (len_err) n_len++;
        if (timeout_err) n_to++;
        if (overrun) n_ovr++;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_cyc.push_back(cyc);
            if (out_last) begin
                last_idx = got.size() - 1;
                last_flen = int'(frame_len);
            end
        end
    end

    initial begin
        #(1_000_000);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_flen", frame_len, 5'd0);
        check("rst_errs", {csum_err, len_err, timeout_err, overrun}, 4'b0);
        repeat (2) @(posedge clk_50M);
        #1 rst = 1'b0;
        idle(2);

        // basic frame
        clear_obs();
        send({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 1'b1);
        idle(6);
        check_got("basic", {8'h11, 8'h22, 8'h33});
        if (got_cyc.size() == 3)
            check("basic_consec", got_cyc[2] - got_cyc[0], 2);
        check("basic_last_idx", last_idx, 2);
        check("basic_flen", last_flen, 3);
        check("basic_errs", n_csum + n_len + n_to + n_ovr, 0);

        // bad checksum, then a good frame right after
        clear_obs();
        send({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68}, 1'b1);
        idle(3);
        check("csum_pulses", n_csum, 1);
        check("csum_nodata", got.size(), 0);
        send({8'hA5, 8'h02, 8'h01, 8'h02, 8'h05}, 1'b1);
        idle(5);
        check_got("after_csum", {8'h01, 8'h02});

        // length errors and leading garbage
        clear_obs();
        send({8'hA5, 8'h00, 8'hA5, 8'h11}, 1'b1);
        idle(2);
        check("len_pulses", n_len, 2);
        send({8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F}, 1'b1);
        idle(4);
        check_got("garbage", {8'h7E});
        check("garbage_flen", last_flen, 1);

        // inter-byte timeout timing
        clear_obs();
        send({8'hA5, 8'h02, 8'hAA}, 1'b1);
        n = 0;
        seen = 0;
        while (!seen && n < T + 10) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
            seen = timeout_err;
        end
        check("to_seen", seen, 1'b1);
        check("to_idle_cycles", n, T - 1);
        idle(2);
        check("to_pulses", n_to, 1);
        send({8'hA5, 8'h01, 8'h42, 8'h43}, 1'b1);
        idle(3);
        check_got("after_to", {8'h42});

        // byte on the expiry cycle keeps the frame alive
        clear_obs();
        send({8'hA5, 8'h02, 8'hAA}, 1'b1);
        idle(T - 2);
        send({8'hBB, 8'h67}, 1'b1);
        idle(4);
        check("expiry_no_to", n_to, 0);
        check_got("expiry", {8'hAA, 8'hBB});

        // back-pressure with a byte arriving during drain
        clear_obs();
        send({8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E},
             1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        idle(4);
        check_got("stall", {8'h01, 8'h02, 8'h03, 8'h04});
        check("stall_overrun", n_ovr, 1);
        check("stall_last_idx", last_idx, 3);

        // asynchronous reset mid-payload
        clear_obs();
        send({8'hA5, 8'h03, 8'h11}, 1'b1);
        check("pre_rst_flen", frame_len, 5'd3);
        #4 rst = 1'b1;
        model_reset();
        #1;
        check("arst_flen", frame_len, 5'd0);
        check("arst_valid", out_valid, 1'b0);
        check("arst_data", out_data, 8'h00);
        repeat (2) @(posedge clk_50M);
        #1 rst = 1'b0;
        send({8'hA5, 8'h01, 8'h42, 8'h43}, 1'b1);
        idle(4);
        check_got("post_rst", {8'h42});
        check("post_rst_errs", n_csum + n_len + n_to + n_ovr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
Sits directly downstream of the UART receiver and consumes its byte strobe (rx_msg/rx_complete). Hunts for a sync byte, then collects a length byte, a payload and an additive checksum byte. A frame is released to the consumer only after its checksum verifies; the payload is buffered internally and then streamed out over a valid/ready interface. Malformed, corrupt or stalled frames are discarded and flagged with error pulses.

Parameters:
SYNC_BYTE, 8'hA5, start-of-frame marker.
MAX_LEN, 16, maximum payload bytes; legal LEN is 1..MAX_LEN.
TIMEOUT_CYCLES, 8680, inter-byte timeout in clk_50M cycles (20 bit times at 115200 baud).

Ports:
clk_50M  in  1  system clock, 50 MHz.
rst  in  1  reset, asynchronous, active-high.
rx_msg  in  8  received byte, valid when rx_complete=1.
rx_complete  in  1  byte strobe from the receiver; every cycle it is high counts as one byte.
out_data  out  8  payload byte.
out_valid  out  1  out_data valid.
out_ready  in  1  consumer accepts the byte when out_valid & out_ready.
out_last  out  1  high with the final payload byte of the frame.
frame_len  out  5  LEN of the frame being streamed; held stable during DRAIN.
csum_err  out  1  one-cycle pulse: checksum mismatch.
len_err  out  1  one-cycle pulse: LEN=0 or LEN>MAX_LEN.
timeout_err  out  1  one-cycle pulse: inter-byte timeout.
overrun  out  1  one-cycle pulse: a byte arrived during DRAIN and was dropped.

Behaviour:
- Clock and reset: one clock, clk_50M. Reset is asynchronous and active-high. Reset forces state=HUNT and clears every output, the counters, the running sum and the write/read pointers to 0, at any point in a frame.
- The state machine advances only on cycles with rx_complete=1 ("byte event"), except in DRAIN and on timeout.
- HUNT: a byte event with rx_msg==SYNC_BYTE goes to LEN. Any other byte is silently ignored.
- LEN: on a byte event:
  - LEN==0 or LEN>MAX_LEN: pulse len_err, go to HUNT.
  - otherwise: store LEN, set sum=LEN, reset write pointer, go to PAYLOAD.
- PAYLOAD: each byte event writes buffer[wptr] and adds the byte to sum (mod 256). After LEN bytes, go to CSUM.
- CSUM: on a byte event:
  - byte == sum[7:0]: go to DRAIN. out_valid rises the next cycle.
  - mismatch: pulse csum_err, go to HUNT.
- DRAIN: out_data=buffer[rptr]. The read pointer advances on out_valid & out_ready. out_last=1 when rptr==LEN-1. Accepting the last byte drops out_valid the next cycle and returns to HUNT. out_data and out_valid stay stable while out_ready=0.
- DRAIN byte events: the byte is dropped and overrun pulses. SYNC_BYTE received in DRAIN is not remembered.
- Timeout: an idle counter runs in LEN, PAYLOAD and CSUM, and is cleared on each byte event. When it reaches TIMEOUT_CYCLES-1: pulse timeout_err, go to HUNT. A byte event in the same cycle as expiry wins (the counter clears, no timeout). The counter is held at 0 in HUNT and DRAIN.
- Simultaneous events: error pulses are mutually exclusive by construction. After an error, a SYNC_BYTE arriving on the next byte event is honoured.
- Widths: sum is 8-bit, wrapping. Pointers are clog2(MAX_LEN) bits. frame_len is 5 bits (MAX_LEN ≤ 31).
- Latency: CSUM byte event → out_valid high 1 cycle later. With out_ready held high, one byte per cycle.

Decomposition:
- uart_pkg: state encodings (HUNT, LEN, PAYLOAD, CSUM, DRAIN), SYNC_BYTE default, TIMEOUT_CYCLES default, CYCLES_PER_BIT=434.
- Sub-module uart_frame_buf: MAX_LEN x 8 register array, one write port and one combinational read port, no reset on contents.

Test Plan:
- Stream A5 03 11 22 33 69 with out_ready=1 → out_data 11,22,33 on consecutive cycles, out_last on 33, frame_len=3, no error pulses.
- Same frame with checksum 68 → csum_err pulses once, out_valid never rises. A following valid frame streams correctly.
- A5 00 → len_err. A5 11 (17>MAX_LEN) → len_err. Leading garbage 00 FF A5 01 7E 7F → payload 7E delivered.
- A5 02 AA, then idle for TIMEOUT_CYCLES → timeout_err after exactly TIMEOUT_CYCLES-1 idle cycles, state HUNT. Byte event at the expiry cycle → no timeout.
- Valid 4-byte frame with out_ready toggling 1,0,0,1 and a byte injected during DRAIN → data held stable while stalled, overrun pulses once, all 4 bytes delivered in order.
- Assert rst mid-PAYLOAD → all outputs 0 immediately (asynchronous). After release, A5 01 42 43 → 42 delivered.
